// File: rtl/button_press_decoder_pkg.sv
// button_press_decoder_pkg: shared FSM encoding and default counter width.
package button_press_decoder_pkg;
   localparam int CNT_WIDTH_DEF = 24;
   typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE} state_t;
endpackage

// File: rtl/button_press_decoder_sync_ff.sv
// button_press_decoder_sync_ff: STAGES-deep synchroniser for the raw button pin.
module button_press_decoder_sync_ff #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q, sync_d;
   always_comb sync_d = {sync_q[STAGES-2:0], d};
   always_ff @(posedge clk)
      if (rst) sync_q <= {STAGES{RST_VAL}};
      else     sync_q <= sync_d;
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/button_press_decoder.sv
// button_press_decoder: synchronise, debounce and classify a push-button into short/long presses.
module button_press_decoder
   import button_press_decoder_pkg::*;
#(
   parameter int                   SYNC_STAGES       = 2,
   parameter int                   CNT_WIDTH         = CNT_WIDTH_DEF,
   parameter logic [CNT_WIDTH-1:0] DEBOUNCE_CYCLES   = CNT_WIDTH'(500_000),
   parameter logic [CNT_WIDTH-1:0] LONG_PRESS_CYCLES = CNT_WIDTH'(12_500_000),
   parameter logic                 BTN_ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       btn_level,
   output logic       press_short,
   output logic       press_long,
   output logic [7:0] press_count
);
   localparam logic [CNT_WIDTH-1:0] DEB_LAST  = DEBOUNCE_CYCLES - 1'b1;
   localparam logic [CNT_WIDTH-1:0] LONG_LAST = LONG_PRESS_CYCLES - 1'b1;

   logic                 btn_raw, btn_sync;
   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
   logic                 level_q, level_d, short_q, short_d, long_q, long_d;
   logic                 from_long_q, from_long_d;
   logic [7:0]           count_q, count_d;

   button_press_decoder_sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(BTN_ACTIVE_LOW)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (btn_raw)
   );

   assign btn_sync = btn_raw ^ BTN_ACTIVE_LOW;

   // cnt holds the press-debounce count, then the hold time; rcnt times the release debounce
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rcnt_d      = rcnt_q;
      level_d     = level_q;
      short_d     = 1'b0;
      long_d      = 1'b0;
      from_long_d = from_long_q;
      count_d     = count_q;
      case (state_q)
         IDLE: if (btn_sync) begin
            state_d = DEB_PRESS;
            cnt_d   = '0;
         end
         DEB_PRESS:
            if (!btn_sync) state_d = IDLE;
            else if (cnt_q == DEB_LAST) begin
               state_d     = HELD;
               level_d     = 1'b1;
               count_d     = count_q + 8'd1;
               cnt_d       = '0;
               from_long_d = 1'b0;
            end else cnt_d = cnt_q + 1'b1;
         HELD:
            if (!btn_sync) begin
               state_d = DEB_RELEASE;
               rcnt_d  = '0;
            end else if (cnt_q == LONG_LAST) begin
               state_d     = LONG_HELD;
               long_d      = 1'b1;
               from_long_d = 1'b1;
            end else cnt_d = cnt_q + 1'b1;
         LONG_HELD: if (!btn_sync) begin
            state_d = DEB_RELEASE;
            rcnt_d  = '0;
         end
         DEB_RELEASE:
            if (btn_sync) state_d = from_long_q ? LONG_HELD : HELD;
            else if (rcnt_q == DEB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               short_d = !from_long_q;
            end else rcnt_d = rcnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk)
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rcnt_q      <= '0;
         level_q     <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         from_long_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rcnt_q      <= rcnt_d;
         level_q     <= level_d;
         short_q     <= short_d;
         long_q      <= long_d;
         from_long_q <= from_long_d;
         count_q     <= count_d;
      end

   assign btn_level   = level_q;
   assign press_short = short_q;
   assign press_long  = long_q;
   assign press_count = count_q;
endmodule

// File: tb/tb_button_press_decoder.sv
// tb_button_press_decoder: run-length reference model plus directed timing checks and random stimulus.
module tb_button_press_decoder;
   localparam int SS = 2, DEB = 4, LNG = 20;

   logic       clk = 1'b0, rst = 1'b1, btn_in = 1'b1;
   logic       btn_level, press_short, press_long;
   logic [7:0] press_count;

   int total = 0, bad = 0, cyc = 0;
   bit started = 0;

   button_press_decoder #(
      .SYNC_STAGES(SS), .CNT_WIDTH(24), .DEBOUNCE_CYCLES(24'd4),
      .LONG_PRESS_CYCLES(24'd20), .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
      .press_short(press_short), .press_long(press_long), .press_count(press_count)
   );

   always #5 clk = ~clk;

   // Model: the accepted level flips once the synchronised input has disagreed with it
   // for DEB+1 consecutive samples; hold time accrues only on agreeing samples.
   bit [SS-1:0] sh;
   bit          m_level, m_short, m_long, long_done, s;
   int          run, hold;
   logic [7:0]  m_count;

   always @(posedge clk) begin
      cyc++;
      started = 1;
      m_short = 0;
      m_long  = 0;
      if (rst) begin
         sh = '0; m_level = 0; run = 0; hold = 0; long_done = 0; m_count = 0;
      end else begin
         s  = sh[SS-1];
         sh = {sh[SS-2:0], (btn_in == 1'b0)};
         if (s != m_level) begin
            run++;
            if (run == DEB + 1) begin
               m_level = s;
               run     = 0;
               if (s) begin
                  m_count++;
                  hold      = 0;
                  long_done = 0;
               end else if (!long_done) m_short = 1;
            end
         end else begin
            if (run == 0 && m_level && !long_done) begin
               if (hold == LNG - 1) begin
                  m_long    = 1;
                  long_done = 1;
               end else hold++;
            end
            run = 0;
         end
      end
   end

   always @(negedge clk)
      if (started) begin
         total++;
         if ({btn_level, press_short, press_long, press_count} !== {m_level, m_short, m_long, m_count}) begin
            bad++;
            $display("FAIL model_cmp cycle %0d: dut lvl=%b short=%b long=%b cnt=%0d, model lvl=%b short=%b long=%b cnt=%0d",
                     cyc, btn_level, press_short, press_long, press_count, m_level, m_short, m_long, m_count);
         end
      end

   int   n_rise = 0, n_fall = 0, n_short = 0, n_long = 0;
   int   rise_cyc = 0, fall_cyc = 0, short_cyc = 0, long_cyc = 0;
   logic prev_level = 1'b0;

   always @(negedge clk)
      if (started) begin
         if (btn_level === 1'b1 && prev_level !== 1'b1) begin n_rise++; rise_cyc = cyc; end
         if (btn_level === 1'b0 && prev_level === 1'b1) begin n_fall++; fall_cyc = cyc; end
         if (press_short === 1'b1) begin n_short++; short_cyc = cyc; end
         if (press_long === 1'b1) begin n_long++; long_cyc = cyc; end
         prev_level = btn_level;
      end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input bit pressed, input int n);
      btn_in = pressed ? 1'b0 : 1'b1;
      repeat (n) @(negedge clk);
   endtask

   int t0, t1, r0, f0, s0, l0;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_level", int'(btn_level), 0);
      chk("reset_count", int'(press_count), 0);
      drive(0, 5);
      // clean short press
      s0 = n_short; l0 = n_long;
      t0 = cyc; drive(1, 15);
      t1 = cyc; drive(0, 20);
      chk("t1_rise_latency", rise_cyc - t0, 7);
      chk("t1_fall_latency", fall_cyc - t1, 7);
      chk("t1_short_at_fall", short_cyc, fall_cyc);
      chk("t1_short_pulses", n_short - s0, 1);
      chk("t1_long_pulses", n_long - l0, 0);
      chk("t1_count", int'(press_count), 1);
      // bounces shorter than the debounce window
      r0 = n_rise; s0 = n_short; l0 = n_long;
      drive(1, 1); drive(0, 2); drive(1, 2); drive(0, 2); drive(1, 3); drive(0, 12);
      chk("t2_no_rise", n_rise - r0, 0);
      chk("t2_no_pulses", (n_short - s0) + (n_long - l0), 0);
      chk("t2_count", int'(press_count), 1);
      // long hold
      s0 = n_short; l0 = n_long;
      t0 = cyc; drive(1, 40);
      t1 = cyc; drive(0, 15);
      chk("t3_long_after_rise", long_cyc - rise_cyc, 20);
      chk("t3_rise_latency", rise_cyc - t0, 7);
      chk("t3_long_pulses", n_long - l0, 1);
      chk("t3_no_short", n_short - s0, 0);
      chk("t3_fall_latency", fall_cyc - t1, 7);
      chk("t3_count", int'(press_count), 2);
      // release glitch while held
      r0 = n_rise; f0 = n_fall; s0 = n_short; l0 = n_long;
      drive(1, 10); drive(0, 2); drive(1, 30); drive(0, 15);
      chk("t4_one_rise", n_rise - r0, 1);
      chk("t4_one_fall", n_fall - f0, 1);
      chk("t4_no_short", n_short - s0, 0);
      chk("t4_one_long", n_long - l0, 1);
      chk("t4_count", int'(press_count), 3);
      // reset in the middle of a hold
      s0 = n_short; l0 = n_long;
      drive(1, 17);
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_level", int'(btn_level), 0);
      chk("t5_rst_count", int'(press_count), 0);
      rst = 1'b0;
      t0 = cyc;
      drive(1, 15);
      chk("t5_rerise_latency", rise_cyc - t0, 7);
      chk("t5_count", int'(press_count), 1);
      chk("t5_no_pulses", (n_short - s0) + (n_long - l0), 0);
      drive(0, 15);
      // 256 presses wrap the counter
      rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
      s0 = n_short; l0 = n_long;
      repeat (256) begin drive(1, 8); drive(0, 10); end
      chk("t6_count_wrap", int'(press_count), 0);
      chk("t6_short_pulses", n_short - s0, 256);
      chk("t6_long_pulses", n_long - l0, 0);
      // random segments, with occasional resets
      repeat (1500) begin
         if ($urandom_range(0, 60) == 0) begin
            rst = 1'b1; @(negedge clk); rst = 1'b0;
         end
         drive(bit'($urandom_range(0, 1)), int'($urandom_range(1, 30)));
      end
      drive(0, 20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
